// File: rtl/filter_arbiter_if.sv
// Handshake bundle between filter_arbiter, its filter buffers and the force pipeline.
// The master modport is the arbiter's view; slave is the filter-bank/pipeline side.
interface filter_arbiter_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int NUM_FILTER        = 8,
  parameter int FILTER_SEL_WIDTH  = 3
);
  localparam int PAIR_WIDTH = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH;

  logic [NUM_FILTER-1:0]            particle_pair_available;
  logic [NUM_FILTER*PAIR_WIDTH-1:0] filter_pair_in;
  logic                             pipeline_stall;
  logic [NUM_FILTER-1:0]            sel;
  logic                             out_valid;
  logic [PARTICLE_ID_WIDTH-1:0]     ref_particle_id_out;
  logic [PARTICLE_ID_WIDTH-1:0]     neighbor_particle_id_out;
  logic [DATA_WIDTH-1:0]            r2;
  logic [DATA_WIDTH-1:0]            dz;
  logic [DATA_WIDTH-1:0]            dy;
  logic [DATA_WIDTH-1:0]            dx;
  logic [FILTER_SEL_WIDTH-1:0]      out_filter_idx;
  logic [31:0]                      pair_count;

  modport master (
    input  particle_pair_available, filter_pair_in, pipeline_stall,
    output sel, out_valid, ref_particle_id_out, neighbor_particle_id_out,
           r2, dz, dy, dx, out_filter_idx, pair_count
  );

  modport slave (
    output particle_pair_available, filter_pair_in, pipeline_stall,
    input  sel, out_valid, ref_particle_id_out, neighbor_particle_id_out,
           r2, dz, dy, dx, out_filter_idx, pair_count
  );
endinterface

// File: rtl/filter_arbiter.sv
// Round-robin arbiter popping one filter buffer per grant and forwarding the pair word.
// Define FILTER_ARBITER_STAT_EN to build the live forwarded-pair counter on pair_count.
module filter_arbiter #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int NUM_FILTER        = 8,
  parameter int FILTER_SEL_WIDTH  = 3
) (
  input  logic              clk,
  input  logic              rst,
  filter_arbiter_if.master  bus
);
  localparam int PAIR_WIDTH = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t                      state_q;
  state_t                      state_d;
  logic [NUM_FILTER-1:0]       req;
  logic [NUM_FILTER-1:0]       sel_q;
  logic [NUM_FILTER-1:0]       sel_d;
  logic [FILTER_SEL_WIDTH-1:0] last_grant_q;
  logic [FILTER_SEL_WIDTH-1:0] last_grant_d;
  logic [FILTER_SEL_WIDTH-1:0] grant_idx;
  logic                        grant_found;

  logic                        vld_p1;
  logic [FILTER_SEL_WIDTH-1:0] idx_p1;
  logic [PAIR_WIDTH-1:0]       slot_p1;

  logic                         out_valid_p2;
  logic [FILTER_SEL_WIDTH-1:0]  idx_p2;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id_p2;
  logic [PARTICLE_ID_WIDTH-1:0] nb_id_p2;
  logic [DATA_WIDTH-1:0]        r2_p2;
  logic [DATA_WIDTH-1:0]        dz_p2;
  logic [DATA_WIDTH-1:0]        dy_p2;
  logic [DATA_WIDTH-1:0]        dx_p2;

  // Returns {found, index}: first requester after 'last', wrapping around.
  function automatic logic [FILTER_SEL_WIDTH:0] rr_pick(
    input logic [NUM_FILTER-1:0]       r,
    input logic [FILTER_SEL_WIDTH-1:0] last
  );
    logic                        found;
    logic [FILTER_SEL_WIDTH-1:0] idx;
    int                          c;
    found = 1'b0;
    idx   = last;
    for (int i = 1; i <= NUM_FILTER; i++) begin
      c = int'(last) + i;
      if (c >= NUM_FILTER) c = c - NUM_FILTER;
      if (!found && r[c[FILTER_SEL_WIDTH-1:0]]) begin
        found = 1'b1;
        idx   = c[FILTER_SEL_WIDTH-1:0];
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [FILTER_SEL_WIDTH-1:0] onehot_idx(
    input logic [NUM_FILTER-1:0] s
  );
    logic [FILTER_SEL_WIDTH-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_FILTER; k++) begin
      if (s[k]) idx = idx | FILTER_SEL_WIDTH'(k);
    end
    return idx;
  endfunction

  // Grant stage: the filter popped this cycle is masked since its flag is still stale.
  always_comb begin
    req          = bus.particle_pair_available & ~sel_q;
    {grant_found, grant_idx} = rr_pick(req, last_grant_q);
    sel_d        = '0;
    last_grant_d = last_grant_q;
    state_d      = state_q;
    if (bus.pipeline_stall) begin
      state_d = STALL;
    end else begin
      if (grant_found) begin
        sel_d[grant_idx] = 1'b1;
        last_grant_d     = grant_idx;
      end
      case (state_q)
        IDLE:    if (grant_found)  state_d = ACTIVE;
        ACTIVE:  if (!grant_found) state_d = IDLE;
        STALL:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= FILTER_SEL_WIDTH'(NUM_FILTER - 1);
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  // p1: buffer q of the popped filter is valid this cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
    end else begin
      vld_p1 <= |sel_q;
      idx_p1 <= onehot_idx(sel_q);
    end
  end

  always_comb begin
    slot_p1 = '0;
    for (int k = 0; k < NUM_FILTER; k++) begin
      if (idx_p1 == FILTER_SEL_WIDTH'(k)) slot_p1 = bus.filter_pair_in[k*PAIR_WIDTH +: PAIR_WIDTH];
    end
  end

  // p2: registered pair word presented to the force pipeline
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_p2 <= 1'b0;
      idx_p2       <= '0;
      ref_id_p2    <= '0;
      nb_id_p2     <= '0;
      r2_p2        <= '0;
      dz_p2        <= '0;
      dy_p2        <= '0;
      dx_p2        <= '0;
    end else begin
      out_valid_p2 <= vld_p1;
      if (vld_p1) begin
        idx_p2    <= idx_p1;
        ref_id_p2 <= slot_p1[PAIR_WIDTH-1 -: PARTICLE_ID_WIDTH];
        nb_id_p2  <= slot_p1[PAIR_WIDTH-PARTICLE_ID_WIDTH-1 -: PARTICLE_ID_WIDTH];
        r2_p2     <= slot_p1[4*DATA_WIDTH-1 -: DATA_WIDTH];
        dz_p2     <= slot_p1[3*DATA_WIDTH-1 -: DATA_WIDTH];
        dy_p2     <= slot_p1[2*DATA_WIDTH-1 -: DATA_WIDTH];
        dx_p2     <= slot_p1[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef FILTER_ARBITER_STAT_EN
  logic [31:0] pair_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pair_cnt_q <= '0;
    end else if (out_valid_p2) begin
      pair_cnt_q <= pair_cnt_q + 32'd1;
    end
  end

  assign bus.pair_count = pair_cnt_q;
`else
  assign bus.pair_count = 32'd0;
`endif

  assign bus.sel                      = sel_q;
  assign bus.out_valid                = out_valid_p2;
  assign bus.out_filter_idx           = idx_p2;
  assign bus.ref_particle_id_out      = ref_id_p2;
  assign bus.neighbor_particle_id_out = nb_id_p2;
  assign bus.r2                       = r2_p2;
  assign bus.dz                       = dz_p2;
  assign bus.dy                       = dy_p2;
  assign bus.dx                       = dx_p2;

  a_sel_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(sel_q));
  a_sel_avail:  assert property (@(posedge clk) disable iff (!rst)
                  (sel_q & ~$past(bus.particle_pair_available)) == '0);
  a_sel_norep:  assert property (@(posedge clk) disable iff (!rst)
                  (sel_q & $past(sel_q)) == '0);
endmodule

// File: tb/tb_filter_arbiter.sv
// Directed bench for filter_arbiter: a per-filter buffer model pops on sel with one-cycle lag.
module tb_filter_arbiter;
  localparam int DW  = 32;
  localparam int PID = 20;
  localparam int NF  = 8;
  localparam int FSW = 3;
  localparam int PW  = 2*PID + 4*DW;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  filter_arbiter_if #(.DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(PID), .NUM_FILTER(NF),
                      .FILTER_SEL_WIDTH(FSW)) bus ();

  filter_arbiter #(.DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(PID), .NUM_FILTER(NF),
                   .FILTER_SEL_WIDTH(FSW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [PW-1:0] slot [NF];
  int            head [NF];
  int            tail [NF];
  logic [NF-1:0] pend;

  for (genvar g = 0; g < NF; g++) begin : g_slot
    assign bus.filter_pair_in[g*PW +: PW] = slot[g];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  function automatic logic [PW-1:0] make_pair(input int k, input int j);
    return {PID'(k*16 + j + 1), PID'(32'hA0000 + k*16 + j), 32'(32'h3F80_0000 + k*256 + j),
            32'(32'hC000_0000 + k*256 + j), 32'(32'h1111_0000 + k*256 + j),
            32'(32'h2222_0000 + k*256 + j)};
  endfunction

  function automatic logic [PW-1:0] out_word();
    return {bus.ref_particle_id_out, bus.neighbor_particle_id_out, bus.r2, bus.dz, bus.dy, bus.dx};
  endfunction

  task automatic update_avail();
    for (int k = 0; k < NF; k++) bus.particle_pair_available[3'(k)] = (head[k] < tail[k]);
  endtask

  // One clock: pops requested last cycle land after the edge; returns at the next negedge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NF; k++) begin
      if (pend[3'(k)]) begin
        slot[k] = make_pair(k, head[k]);
        head[k] = head[k] + 1;
      end
    end
    update_avail();
    @(negedge clk);
    pend = bus.sel;
  endtask

  task automatic load(input int k, input int n);
    tail[k] = tail[k] + n;
    update_avail();
  endtask

  task automatic reset_and_clear();
    rst = 1'b0;
    bus.pipeline_stall = 1'b0;
    for (int k = 0; k < NF; k++) begin
      head[k] = 0;
      tail[k] = 0;
      slot[k] = '0;
    end
    pend = '0;
    update_avail();
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset_and_clear();
    for (int k = 0; k < NF; k++) load(k, 2);
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (bus.sel !== 8'h00) begin bad++; $display("FAIL reset_sel got=%h exp=00", bus.sel); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      total++; if (out_word() !== '0) begin bad++; $display("FAIL reset_word got=%h exp=0", out_word()); end
      total++; if (bus.out_filter_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", bus.out_filter_idx); end
      total++; if (bus.pair_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.pair_count); end
    end
    rst = 1'b1;
    step();
    total++; if (bus.sel !== 8'h01) begin bad++; $display("FAIL reset_first_sel got=%h exp=01", bus.sel); end
  endtask

  task automatic test_all_available();
    logic [NF-1:0] es;
    reset_and_clear();
    for (int k = 0; k < NF; k++) load(k, 2);
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      es = 8'(1 << ((i - 1) % 8));
      total++; if (bus.sel !== es) begin bad++; $display("FAIL all_sel c%0d got=%h exp=%h", i, bus.sel, es); end
      total++; if (bus.out_valid !== (i >= 3)) begin bad++; $display("FAIL all_valid c%0d got=%b exp=%b", i, bus.out_valid, i >= 3); end
      if (i >= 3) begin
        total++; if (bus.out_filter_idx !== 3'((i - 3) % 8)) begin bad++; $display("FAIL all_idx c%0d got=%0d exp=%0d", i, bus.out_filter_idx, (i - 3) % 8); end
        total++; if (out_word() !== make_pair((i - 3) % 8, (i - 3) / 8)) begin bad++; $display("FAIL all_word c%0d got=%h exp=%h", i, out_word(), make_pair((i - 3) % 8, (i - 3) / 8)); end
      end
    end
  endtask

  task automatic test_single_source();
    logic [NF-1:0] es;
    logic          ev;
    int            n;
    reset_and_clear();
    load(5, 4);
    rst = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      es = (i <= 7 && (i % 2) == 1) ? 8'h20 : 8'h00;
      ev = (i >= 3 && i <= 9 && (i % 2) == 1);
      total++; if (bus.sel !== es) begin bad++; $display("FAIL single_sel c%0d got=%h exp=%h", i, bus.sel, es); end
      total++; if (bus.out_valid !== ev) begin bad++; $display("FAIL single_valid c%0d got=%b exp=%b", i, bus.out_valid, ev); end
      if (ev) begin
        total++; if (bus.out_filter_idx !== 3'd5) begin bad++; $display("FAIL single_idx c%0d got=%0d exp=5", i, bus.out_filter_idx); end
        total++; if (out_word() !== make_pair(5, n)) begin bad++; $display("FAIL single_word c%0d got=%h exp=%h", i, out_word(), make_pair(5, n)); end
        n++;
      end
    end
    total++; if (dut.state_q !== 2'd0) begin bad++; $display("FAIL single_state got=%0d exp=0(IDLE)", dut.state_q); end
  endtask

  task automatic test_stall();
    reset_and_clear();
    for (int k = 0; k < NF; k++) load(k, 4);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (bus.sel !== 8'(1 << (i - 1))) begin bad++; $display("FAIL stall_pre_sel c%0d got=%h exp=%h", i, bus.sel, 8'(1 << (i - 1))); end
    end
    bus.pipeline_stall = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      step();
      total++; if (bus.sel !== 8'h00) begin bad++; $display("FAIL stall_sel c%0d got=%h exp=00", i, bus.sel); end
      total++; if (bus.out_valid !== (i <= 5)) begin bad++; $display("FAIL stall_valid c%0d got=%b exp=%b", i, bus.out_valid, i <= 5); end
      if (i <= 5) begin
        total++; if (bus.out_filter_idx !== 3'(i - 3)) begin bad++; $display("FAIL stall_idx c%0d got=%0d exp=%0d", i, bus.out_filter_idx, i - 3); end
      end
      if (i == 6) begin
        total++; if (dut.state_q !== 2'd2) begin bad++; $display("FAIL stall_state got=%0d exp=2(STALL)", dut.state_q); end
      end
    end
    bus.pipeline_stall = 1'b0;
    step();
    total++; if (bus.sel !== 8'h08) begin bad++; $display("FAIL stall_resume_sel got=%h exp=08", bus.sel); end
    step();
    total++; if (bus.sel !== 8'h10) begin bad++; $display("FAIL stall_resume_sel2 got=%h exp=10", bus.sel); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_gap_valid got=%b exp=0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_filter_idx !== 3'd3) begin bad++; $display("FAIL stall_resume_out got=%b/%0d exp=1/3", bus.out_valid, bus.out_filter_idx); end
  endtask

  task automatic test_fairness();
    logic [NF-1:0] es;
    logic [NF-1:0] prev;
    int            ei;
    reset_and_clear();
    load(0, 4);
    load(7, 4);
    rst = 1'b1;
    prev = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      es = (i > 8) ? 8'h00 : ((i % 2) == 1 ? 8'h01 : 8'h80);
      total++; if (bus.sel !== es) begin bad++; $display("FAIL fair_sel c%0d got=%h exp=%h", i, bus.sel, es); end
      total++; if ((bus.sel & prev) !== 8'h00) begin bad++; $display("FAIL fair_repeat c%0d got=%h exp=00", i, bus.sel & prev); end
      prev = bus.sel;
      if (i >= 3) begin
        ei = ((i - 3) % 2 == 1) ? 7 : 0;
        total++; if (bus.out_valid !== 1'b1 || out_word() !== make_pair(ei, (i - 3) / 2)) begin bad++; $display("FAIL fair_out c%0d got=%b/%h exp=1/%h", i, bus.out_valid, out_word(), make_pair(ei, (i - 3) / 2)); end
      end
    end
  endtask

  task automatic test_stat();
    reset_and_clear();
`ifdef FILTER_ARBITER_STAT_EN
    load(0, 1);
    rst = 1'b1;
    step();
    step();
    force dut.pair_cnt_q = 32'hFFFF_FFFF;
    release dut.pair_cnt_q;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.pair_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL stat_preload got=%b/%h exp=1/ffffffff", bus.out_valid, bus.pair_count); end
    step();
    total++; if (bus.pair_count !== 32'd0) begin bad++; $display("FAIL stat_wrap got=%h exp=00000000", bus.pair_count); end
`else
    load(3, 3);
    load(4, 2);
    rst = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      total++; if (bus.pair_count !== 32'd0) begin bad++; $display("FAIL stat_tied c%0d got=%0d exp=0", i, bus.pair_count); end
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.pipeline_stall = 1'b0;
    bus.particle_pair_available = '0;
    pend = '0;
    for (int k = 0; k < NF; k++) begin
      slot[k] = '0;
      head[k] = 0;
      tail[k] = 0;
    end
    test_reset();
    test_all_available();
    test_single_source();
    test_stall();
    test_fairness();
    test_stat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
